// File: rtl/idex_pkg.sv
// Shared types for the ID/EX pipeline stage: the decoded bundle layout,
// the skid-buffer state encoding and the flattened bundle width.
package idex_pkg;

    localparam int DATA_W    = 16;
    localparam int RADDR_W   = 3;
    localparam int ALUOP_W   = 2;
    localparam int SHIFT_W   = 2;
    localparam int CNT_W_DEF = 16;

    typedef struct packed {
        logic [DATA_W-1:0]  instr;
        logic [DATA_W-1:0]  rn;
        logic [DATA_W-1:0]  rm;
        logic [DATA_W-1:0]  imm5;
        logic [DATA_W-1:0]  imm8;
        logic [RADDR_W-1:0] rn_num;
        logic [RADDR_W-1:0] rm_num;
        logic [RADDR_W-1:0] rd_num;
        logic [ALUOP_W-1:0] aluop;
        logic [SHIFT_W-1:0] shift;
        logic               write;
    } idex_bundle_t;

    localparam int BUNDLE_W = $bits(idex_bundle_t);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer with synchronous flush and a registered ready.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_EMPTY | main entry invalid, nothing presented downstream
// ST_FULL  | main entry valid, skid entry free
// ST_SKID  | both entries valid, upstream is back-pressured
module pipe_skid_reg
    import idex_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             main_vld_q, main_vld_d;
    logic             skid_vld_q, skid_vld_d;
    logic             in_ready_q, in_ready_d;
    logic             accept;
    logic             pop;

    // ready comes from a flop so upstream never sees a path from out_ready_i
    assign accept      = in_valid_i & in_ready_q;
    assign pop         = main_vld_q & out_ready_i;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = main_vld_q;
    assign out_data_o  = main_q;

    // next-state and datapath steering; flush overrides every other event
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_data_i;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && pop) begin
                        main_d = in_data_i;
                    end else if (accept) begin
                        skid_d  = in_data_i;
                        state_d = ST_SKID;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        main_vld_d = (state_d != ST_EMPTY);
        skid_vld_d = (state_d == ST_SKID);
        in_ready_d = (state_d != ST_SKID);
    end

    // state, valid bits and payload registers; reset drops all in-flight data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
        end
    end

    // a held skid entry without a main entry would reorder bundles
    a_skid_implies_main: assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(skid_vld_q && !main_vld_q)
    );

endmodule

// File: rtl/idex_skid_stage.sv
// ID/EX stage: skid-buffered decode-to-execute handoff, register-write
// masking on bubbles, and saturating stall/bubble counters.
module idex_skid_stage
    import idex_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  idex_bundle_t     in_bundle,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output idex_bundle_t     out_bundle,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [BUNDLE_W-1:0] main_data;
    logic                main_vld;
    idex_bundle_t        main_bundle;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;

    pipe_skid_reg #(
        .WIDTH (BUNDLE_W)
    ) u_skid (
        .clk_i       (clk),
        .rst_ni      (reset),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_bundle),
        .flush_i     (flush),
        .out_valid_o (main_vld),
        .out_ready_i (out_ready),
        .out_data_o  (main_data)
    );

    assign main_bundle = idex_bundle_t'(main_data);
    assign out_valid   = main_vld;
    assign stall_cnt   = stall_cnt_q;
    assign bubble_cnt  = bubble_cnt_q;

    // a bubble must never write the register file; other fields just hold
    always_comb begin
        out_bundle       = main_bundle;
        out_bundle.write = main_bundle.write & main_vld;
    end

    // saturating counters; stall and bubble conditions are mutually exclusive
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (main_vld && !out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (!main_vld && out_ready && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    // counter registers survive flush, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_idex_skid_stage.sv
// Bench for idex_skid_stage: directed scenarios plus random traffic, all
// compared against a queue-based model of the stage contents.
module tb_idex_skid_stage;
    import idex_pkg::*;

    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    idex_bundle_t      in_bundle;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    idex_bundle_t      out_bundle;
    logic [CW-1:0]     stall_cnt;
    logic [CW-1:0]     bubble_cnt;

    int n_vec = 0;
    int n_err = 0;

    idex_bundle_t mq[$];
    logic         m_ready;
    idex_bundle_t m_last;
    int           m_stall;
    int           m_bubble;

    idex_skid_stage #(.CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bundle  (in_bundle),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bundle (out_bundle),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic idex_bundle_t rand_bundle();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return idex_bundle_t'(r[BUNDLE_W-1:0]);
    endfunction

    function automatic idex_bundle_t mk(input logic [15:0] instr, input logic wr);
        idex_bundle_t b;
        b       = rand_bundle();
        b.instr = instr;
        b.write = wr;
        return b;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ready  = 1'b0;
        m_last   = '0;
        m_stall  = 0;
        m_bubble = 0;
    endtask

    // stage viewed as an ordered list of at most two bundles
    task automatic model_edge();
        bit ov, acc, pop;
        if (!reset) begin
            model_reset();
        end else begin
            ov  = (mq.size() > 0);
            acc = in_valid && m_ready;
            pop = ov && out_ready;
            if (ov && !out_ready && m_stall < MAXC)  m_stall++;
            if (!ov && out_ready && m_bubble < MAXC) m_bubble++;
            if (flush) begin
                mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (acc) mq.push_back(in_bundle);
            end
            if (mq.size() > 0) m_last = mq[0];
            m_ready = (mq.size() < 2);
        end
    endtask

    task automatic check_outputs();
        idex_bundle_t exp;
        exp       = m_last;
        exp.write = m_last.write & (mq.size() > 0);
        check("out_valid",  out_valid,  (mq.size() > 0));
        check("in_ready",   in_ready,   m_ready);
        check("out_bundle", out_bundle, exp);
        check("stall_cnt",  stall_cnt,  m_stall[CW-1:0]);
        check("bubble_cnt", bubble_cnt, m_bubble[CW-1:0]);
    endtask

    // called at a negedge; returns at the next negedge
    task automatic cycle(input bit v, input idex_bundle_t b, input bit fl, input bit ordy);
        in_valid  = v;
        in_bundle = b;
        flush     = fl;
        out_ready = ordy;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic stream8();
        for (int i = 0; i < 8; i++) cycle(1'b1, mk(16'h1000 + 16'(i), 1'b1), 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        bit acc;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_bundle = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        cycle(1'b1, mk(16'hDEAD, 1'b1), 1'b0, 1'b1);
        reset = 1'b1;

        // streaming at full rate
        stream8();
        check("stream_stall", stall_cnt, 0);

        // back-pressure: A on output, B into skid, C held upstream
        cycle(1'b1, mk(16'h00A1, 1'b1), 1'b0, 1'b1);
        cycle(1'b1, mk(16'h00B2, 1'b0), 1'b0, 1'b0);
        check("bp_in_ready_low", in_ready, 0);
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(16'h00C3, 1'b1), 1'b0, 1'b0);
        acc = 1'b0;
        for (int i = 0; i < 6 && !acc; i++) begin
            acc = m_ready;
            cycle(1'b1, mk(16'h00C3, 1'b1), 1'b0, 1'b1);
        end
        check("bp_c_accepted", acc, 1);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);

        // flush while in skid with a concurrent bundle
        cycle(1'b1, mk(16'h0F01, 1'b1), 1'b0, 1'b1);
        cycle(1'b1, mk(16'h0F02, 1'b1), 1'b0, 1'b0);
        cycle(1'b1, mk(16'h0F03, 1'b1), 1'b1, 1'b0);
        check("flush_write", out_bundle.write, 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);

        // bubble masking
        cycle(1'b1, mk(16'h0B0B, 1'b1), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, mk(16'h0, 1'b1), 1'b0, 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 9) < 7), rand_bundle(), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) < 6));

        // asynchronous reset mid-operation while in skid
        cycle(1'b1, mk(16'h5A01, 1'b1), 1'b0, 1'b1);
        cycle(1'b1, mk(16'h5A02, 1'b1), 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_bundle", out_bundle, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_bubble", bubble_cnt, 0);
        model_reset();
        @(negedge clk);
        cycle(1'b1, mk(16'h5A03, 1'b1), 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_release_ready", in_ready, 0);
        stream8();

        // stall counter saturation
        cycle(1'b1, mk(16'h0515, 1'b1), 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b0);
        check("stall_sat", stall_cnt, 15);

        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 9) < 8), rand_bundle(), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 9) < 5));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
